// File: rtl/reversi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reversi_pkg : state encoding, key priority and control-word decode shared  |
// | by the reversi control FSM and datapath.      Revision: 1.0                |
// +----------------------------------------------------------------------------+
package reversi_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1000000;
    localparam int STATE_BITS             = 5;

    typedef enum logic [STATE_BITS-1:0] {
        S_RESET       = 5'd0,
        S_DRAW_BOARD  = 5'd1,
        S_DRAW_INIT   = 5'd2,
        S_MOVE_HL     = 5'd3,
        S_IDLE        = 5'd4,
        S_MOVE_RIGHT  = 5'd5,
        S_MOVE_LEFT   = 5'd6,
        S_MOVE_UP     = 5'd7,
        S_MOVE_DOWN   = 5'd8,
        S_CHECK       = 5'd9,
        S_PLACE       = 5'd10,
        S_FLIP        = 5'd11,
        S_SCORE       = 5'd12,
        S_TURN        = 5'd13,
        S_HAS_CUR     = 5'd14,
        S_HAS_OPP     = 5'd15,
        S_REMOVE_HL   = 5'd16,
        S_WINNER_WAIT = 5'd17
    } state_t;

    // Key vector indices double as priority order: lower index wins.
    localparam int NUM_KEYS  = 5;
    localparam int KEY_ENTER = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_UP    = 3;
    localparam int KEY_DOWN  = 4;

    typedef struct packed {
        logic dp_reset;
        logic draw_board_en;
        logic draw_init_en;
        logic move_hl_en;
        logic check_en;
        logic place_en;
        logic flip_en;
        logic score_en;
        logic turn_en;
        logic has_turn_en;
        logic det_current;
        logic det_opponent;
        logic remove_hl_en;
        logic move_right_en;
        logic move_left_en;
        logic move_up_en;
        logic move_down_en;
        logic write_en;
        logic game_over;
    } ctrl_t;

    function automatic logic is_handshake(input state_t s);
        return s inside {S_RESET, S_DRAW_BOARD, S_DRAW_INIT, S_MOVE_HL, S_CHECK,
                         S_PLACE, S_FLIP, S_SCORE, S_TURN, S_HAS_CUR, S_HAS_OPP,
                         S_REMOVE_HL};
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_RESET:       c.dp_reset = 1'b1;
            S_DRAW_BOARD:  begin c.draw_board_en = 1'b1; c.write_en = 1'b1; end
            S_DRAW_INIT:   begin c.draw_init_en  = 1'b1; c.write_en = 1'b1; end
            S_MOVE_HL:     begin c.move_hl_en    = 1'b1; c.write_en = 1'b1; end
            S_MOVE_RIGHT:  c.move_right_en = 1'b1;
            S_MOVE_LEFT:   c.move_left_en  = 1'b1;
            S_MOVE_UP:     c.move_up_en    = 1'b1;
            S_MOVE_DOWN:   c.move_down_en  = 1'b1;
            S_CHECK:       c.check_en = 1'b1;
            S_PLACE:       c.place_en = 1'b1;
            S_FLIP:        begin c.flip_en  = 1'b1; c.write_en = 1'b1; end
            S_SCORE:       begin c.score_en = 1'b1; c.write_en = 1'b1; end
            S_TURN:        c.turn_en = 1'b1;
            S_HAS_CUR:     begin c.has_turn_en = 1'b1; c.det_current  = 1'b1; end
            S_HAS_OPP:     begin c.has_turn_en = 1'b1; c.det_opponent = 1'b1; end
            S_REMOVE_HL:   begin c.remove_hl_en = 1'b1; c.write_en = 1'b1; end
            S_WINNER_WAIT: c.game_over = 1'b1;
            default:       c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reversi_control_fsm_key_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_edge_detect : registers the debounced keys and emits one-cycle rise    |
// | pulses.                                       Revision: 1.0                |
// +----------------------------------------------------------------------------+
module key_edge_detect
    import reversi_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] rise
);

    logic [NUM_KEYS-1:0] keys_d;
    logic [NUM_KEYS-1:0] keys_q;

    always_comb begin
        keys_d = keys;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            keys_q <= '0;
        end else begin
            keys_q <= keys_d;
        end
    end

    assign rise = keys & ~keys_q;

endmodule
`default_nettype wire

// File: rtl/reversi_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reversi_control_fsm : sequences the reversi datapath one enable at a time, |
// | with go handshakes, pass detection and a per-state timeout. Revision: 1.0  |
// +----------------------------------------------------------------------------+
module reversi_control_fsm
    import reversi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int STATE_W        = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               key_enter,
    input  logic               key_right,
    input  logic               key_left,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               go,
    input  logic               valid_move,
    input  logic               has_turn,
    output logic               dp_reset,
    output logic               draw_board_en,
    output logic               draw_init_en,
    output logic               move_hl_en,
    output logic               check_en,
    output logic               place_en,
    output logic               flip_en,
    output logic               score_en,
    output logic               turn_en,
    output logic               has_turn_en,
    output logic               det_current,
    output logic               det_opponent,
    output logic               remove_hl_en,
    output logic               move_right_en,
    output logic               move_left_en,
    output logic               move_up_en,
    output logic               move_down_en,
    output logic               write_en,
    output logic               game_over,
    output logic               timeout_err,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] key_rise;

    state_t              state_d,       state_q;
    logic [TIMER_W-1:0]  timer_d,       timer_q;
    logic                pass_cnt_d,    pass_cnt_q;
    logic                timeout_err_d, timeout_err_q;
    ctrl_t               ctrl_q;
    logic                timed_out;

    always_comb begin
        keys            = '0;
        keys[KEY_ENTER] = key_enter;
        keys[KEY_RIGHT] = key_right;
        keys[KEY_LEFT]  = key_left;
        keys[KEY_UP]    = key_up;
        keys[KEY_DOWN]  = key_down;
    end

    key_edge_detect u_key_edge_detect (
        .clk    (clk),
        .resetn (resetn),
        .keys   (keys),
        .rise   (key_rise)
    );

    always_comb begin
        state_d       = state_q;
        pass_cnt_d    = pass_cnt_q;
        timeout_err_d = timeout_err_q;
        timed_out     = is_handshake(state_q) && !go && (timer_q == TIMER_LAST);

        case (state_q)
            S_RESET:      if (go) state_d = S_DRAW_BOARD;
            S_DRAW_BOARD: if (go) state_d = S_DRAW_INIT;
            S_DRAW_INIT:  if (go) state_d = S_MOVE_HL;
            S_MOVE_HL:    if (go) state_d = S_IDLE;
            S_IDLE: begin
                if      (key_rise[KEY_ENTER]) state_d = S_CHECK;
                else if (key_rise[KEY_RIGHT]) state_d = S_MOVE_RIGHT;
                else if (key_rise[KEY_LEFT])  state_d = S_MOVE_LEFT;
                else if (key_rise[KEY_UP])    state_d = S_MOVE_UP;
                else if (key_rise[KEY_DOWN])  state_d = S_MOVE_DOWN;
            end
            S_MOVE_RIGHT,
            S_MOVE_LEFT,
            S_MOVE_UP,
            S_MOVE_DOWN:  state_d = S_MOVE_HL;
            S_CHECK:      if (go) state_d = valid_move ? S_PLACE : S_IDLE;
            S_PLACE:      if (go) state_d = S_FLIP;
            S_FLIP:       if (go) state_d = S_SCORE;
            S_SCORE:      if (go) state_d = S_TURN;
            S_TURN:       if (go) state_d = S_HAS_CUR;
            S_HAS_CUR: begin
                if (go) begin
                    if (has_turn) begin
                        pass_cnt_d = 1'b0;
                        state_d    = S_MOVE_HL;
                    end else begin
                        state_d    = S_HAS_OPP;
                    end
                end
            end
            S_HAS_OPP: begin
                // A second consecutive pass means neither side can move.
                if (go) begin
                    if (has_turn && !pass_cnt_q) begin
                        pass_cnt_d = 1'b1;
                        state_d    = S_TURN;
                    end else begin
                        state_d    = S_REMOVE_HL;
                    end
                end
            end
            S_REMOVE_HL:   if (go) state_d = S_WINNER_WAIT;
            S_WINNER_WAIT: if (key_rise[KEY_ENTER]) state_d = S_RESET;
            default:       state_d = S_RESET;
        endcase

        if (timed_out) begin
            state_d       = S_RESET;
            timeout_err_d = 1'b1;
        end

        if ((state_d != state_q) || timed_out) begin
            timer_d = '0;
        end else if (is_handshake(state_q)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Outputs are decoded from the next state so they are registered yet Moore-aligned.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_RESET;
            timer_q       <= '0;
            pass_cnt_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            ctrl_q        <= decode_ctrl(S_RESET);
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pass_cnt_q    <= pass_cnt_d;
            timeout_err_q <= timeout_err_d;
            ctrl_q        <= decode_ctrl(state_d);
        end
    end

    assign dp_reset      = ctrl_q.dp_reset;
    assign draw_board_en = ctrl_q.draw_board_en;
    assign draw_init_en  = ctrl_q.draw_init_en;
    assign move_hl_en    = ctrl_q.move_hl_en;
    assign check_en      = ctrl_q.check_en;
    assign place_en      = ctrl_q.place_en;
    assign flip_en       = ctrl_q.flip_en;
    assign score_en      = ctrl_q.score_en;
    assign turn_en       = ctrl_q.turn_en;
    assign has_turn_en   = ctrl_q.has_turn_en;
    assign det_current   = ctrl_q.det_current;
    assign det_opponent  = ctrl_q.det_opponent;
    assign remove_hl_en  = ctrl_q.remove_hl_en;
    assign move_right_en = ctrl_q.move_right_en;
    assign move_left_en  = ctrl_q.move_left_en;
    assign move_up_en    = ctrl_q.move_up_en;
    assign move_down_en  = ctrl_q.move_down_en;
    assign write_en      = ctrl_q.write_en;
    assign game_over     = ctrl_q.game_over;
    assign timeout_err   = timeout_err_q;
    assign state_dbg     = STATE_W'(state_q);

endmodule
`default_nettype wire
